// File: rtl/alu_reg_sequencer_if.sv
// rtl/alu_reg_sequencer_if.sv - command, register-bank and response signals of the ALU sequencer
interface alu_reg_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] bus_data;
    logic             en_a;
    logic             en_b;
    logic             en_r;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] res_q;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    // Sequencer side: accepts commands, drives the register bank, returns results
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_q, rsp_ready,
        output cmd_ready, bus_data, en_a, en_b, en_r, alu_op, rsp_valid, rsp_data, busy
    );

    // Environment side: issues commands, owns the register bank, consumes results
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_q, rsp_ready,
        input  cmd_ready, bus_data, en_a, en_b, en_r, alu_op, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/alu_reg_sequencer.sv
// rtl/alu_reg_sequencer.sv - sequences one ALU operation over a shared-bus operand/result register bank
module alu_reg_sequencer #(
    parameter int WIDTH       = 8,
    parameter int OP_W        = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_reg_sequencer_if.slave   sif
);
    // Zero settle cycles still needs one EXEC cycle so CAPTURE sees a stable ALU output
    localparam int E_EFF   = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
    localparam int CNT_RAW = $clog2(EXEC_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(E_EFF - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        EXEC    = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             accept;

    assign accept = (state == IDLE) && sif.cmd_valid;

    // State register; async reset discards any in-flight command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the command on accept so later input changes have no effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= sif.cmd_op;
            a_q  <= sif.cmd_a;
            b_q  <= sif.cmd_b;
        end
    end

    // Settle counter: loaded on the way into EXEC, counts down to zero and holds there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (state == LOAD_B) begin
            count <= CNT_LOAD;
        end else if ((state == EXEC) && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Next-state and state-decoded outputs; at most one register enable per state
    always_comb begin
        state_next    = state;
        sif.cmd_ready = 1'b0;
        sif.bus_data  = '0;
        sif.en_a      = 1'b0;
        sif.en_b      = 1'b0;
        sif.en_r      = 1'b0;
        sif.alu_op    = op_q;
        sif.rsp_valid = 1'b0;
        sif.rsp_data  = '0;
        sif.busy      = 1'b1;
        case (state)
            IDLE: begin
                sif.cmd_ready = 1'b1;
                sif.busy      = 1'b0;
                sif.alu_op    = '0;
                if (sif.cmd_valid) begin
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                sif.bus_data = a_q;
                sif.en_a     = 1'b1;
                state_next   = LOAD_B;
            end
            LOAD_B: begin
                sif.bus_data = b_q;
                sif.en_b     = 1'b1;
                state_next   = EXEC;
            end
            EXEC: begin
                if (count == '0) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                sif.en_r   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                sif.rsp_valid = 1'b1;
                sif.rsp_data  = sif.res_q;
                if (sif.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_reg_sequencer.sv
// tb/tb_alu_reg_sequencer.sv - directed self-checking bench for alu_reg_sequencer
module tb_alu_reg_sequencer;
    logic clk;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;

    alu_reg_sequencer_if #(.WIDTH(8), .OP_W(3)) i1 ();
    alu_reg_sequencer_if #(.WIDTH(8), .OP_W(3)) i4 ();
    alu_reg_sequencer_if #(.WIDTH(8), .OP_W(3)) i0 ();

    alu_reg_sequencer #(.WIDTH(8), .OP_W(3), .EXEC_CYCLES(1)) u1 (.clk(clk), .rst(rst), .sif(i1.slave));
    alu_reg_sequencer #(.WIDTH(8), .OP_W(3), .EXEC_CYCLES(4)) u4 (.clk(clk), .rst(rst), .sif(i4.slave));
    alu_reg_sequencer #(.WIDTH(8), .OP_W(3), .EXEC_CYCLES(0)) u0 (.clk(clk), .rst(rst), .sif(i0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    alu = a + b;
            3'd1:    alu = a - b;
            3'd2:    alu = a & b;
            3'd3:    alu = a | b;
            3'd4:    alu = a ^ b;
            default: alu = a;
        endcase
    endfunction

    logic [7:0] a_reg;
    logic [7:0] b_reg;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= 8'h00;
            b_reg    <= 8'h00;
            i1.res_q <= 8'h00;
        end else begin
            if (i1.en_a) a_reg <= i1.bus_data;
            if (i1.en_b) b_reg <= i1.bus_data;
            if (i1.en_r) i1.res_q <= alu(i1.alu_op, a_reg, b_reg);
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ($countones({i1.en_a, i1.en_b, i1.en_r}) > 1) begin
            errors++;
            $error("FAIL onehot_e1: %b", {i1.en_a, i1.en_b, i1.en_r});
        end
        vectors++;
        if ($countones({i4.en_a, i4.en_b, i4.en_r}) > 1) begin
            errors++;
            $error("FAIL onehot_e4: %b", {i4.en_a, i4.en_b, i4.en_r});
        end
        vectors++;
        if ($countones({i0.en_a, i0.en_b, i0.en_r}) > 1) begin
            errors++;
            $error("FAIL onehot_e0: %b", {i0.en_a, i0.en_b, i0.en_r});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int r4, v4, r0, v0;
    logic [7:0] d4, d0;

    initial begin
        rst = 1'b1;
        i1.cmd_valid = 0; i1.cmd_op = 0; i1.cmd_a = 0; i1.cmd_b = 0; i1.rsp_ready = 0;
        i4.cmd_valid = 0; i4.cmd_op = 0; i4.cmd_a = 0; i4.cmd_b = 0; i4.rsp_ready = 1; i4.res_q = 8'h5A;
        i0.cmd_valid = 0; i0.cmd_op = 0; i0.cmd_a = 0; i0.cmd_b = 0; i0.rsp_ready = 1; i0.res_q = 8'hA5;
        repeat (3) tick();

        vectors++;
        if (i1.cmd_ready !== 1'b1) begin errors++; $error("FAIL rst_cmd_ready: %0h", i1.cmd_ready); end
        vectors++;
        if (i1.busy !== 1'b0) begin errors++; $error("FAIL rst_busy: %0h", i1.busy); end
        vectors++;
        if ({i1.en_a, i1.en_b, i1.en_r} !== 3'b000) begin errors++; $error("FAIL rst_en"); end
        vectors++;
        if (i1.bus_data !== 8'h00) begin errors++; $error("FAIL rst_bus: %0h", i1.bus_data); end
        vectors++;
        if ({i1.rsp_valid, i1.rsp_data} !== 9'h000) begin errors++; $error("FAIL rst_rsp"); end
        vectors++;
        if (i1.alu_op !== 3'd0) begin errors++; $error("FAIL rst_alu_op: %0h", i1.alu_op); end
        rst = 1'b0;
        tick();
        vectors++;
        if (i1.cmd_ready !== 1'b1) begin errors++; $error("FAIL idle_cmd_ready"); end
        vectors++;
        if (i1.busy !== 1'b0) begin errors++; $error("FAIL idle_busy"); end

        i1.cmd_op = 3'd0; i1.cmd_a = 8'h12; i1.cmd_b = 8'h34; i1.cmd_valid = 1; i1.rsp_ready = 1;
        tick();
        i1.cmd_valid = 0;
        vectors++;
        if ({i1.en_a, i1.en_b, i1.en_r, i1.bus_data} !== {3'b100, 8'h12}) begin errors++; $error("FAIL t2_c1_bus"); end
        vectors++;
        if ({i1.busy, i1.cmd_ready} !== 2'b10) begin errors++; $error("FAIL t2_c1_busy"); end
        tick();
        vectors++;
        if ({i1.en_a, i1.en_b, i1.en_r, i1.bus_data} !== {3'b010, 8'h34}) begin errors++; $error("FAIL t2_c2_bus"); end
        tick();
        vectors++;
        if ({i1.en_a, i1.en_b, i1.en_r, i1.bus_data} !== {3'b000, 8'h00}) begin errors++; $error("FAIL t2_c3_exec"); end
        tick();
        vectors++;
        if ({i1.en_a, i1.en_b, i1.en_r} !== 3'b001) begin errors++; $error("FAIL t2_c4_en_r"); end
        tick();
        vectors++;
        if (i1.rsp_valid !== 1'b1) begin errors++; $error("FAIL t2_c5_rsp_valid"); end
        vectors++;
        if (i1.rsp_data !== 8'h46) begin errors++; $error("FAIL t2_c5_rsp_data: %0h", i1.rsp_data); end
        tick();
        vectors++;
        if ({i1.rsp_valid, i1.cmd_ready, i1.busy} !== 3'b010) begin errors++; $error("FAIL t2_c6_idle"); end

        i1.cmd_op = 3'd1; i1.cmd_a = 8'h50; i1.cmd_b = 8'h20; i1.cmd_valid = 1; i1.rsp_ready = 0;
        tick();
        i1.cmd_a = 8'hFF; i1.cmd_b = 8'hFF; i1.cmd_op = 3'd4;
        vectors++;
        if (i1.bus_data !== 8'h50) begin errors++; $error("FAIL t3_c1_latched_a: %0h", i1.bus_data); end
        vectors++;
        if (i1.alu_op !== 3'd1) begin errors++; $error("FAIL t3_c1_alu_op: %0h", i1.alu_op); end
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i1.rsp_valid !== 1'b1) begin errors++; $error("FAIL t3_hold_valid"); end
            vectors++;
            if (i1.rsp_data !== 8'h30) begin errors++; $error("FAIL t3_hold_data: %0h", i1.rsp_data); end
            vectors++;
            if (i1.cmd_ready !== 1'b0) begin errors++; $error("FAIL t3_hold_cmd_ready"); end
            tick();
        end
        i1.cmd_valid = 0; i1.rsp_ready = 1;
        tick();
        vectors++;
        if ({i1.rsp_valid, i1.cmd_ready, i1.busy} !== 3'b010) begin errors++; $error("FAIL t3_idle"); end

        r4 = -1; v4 = -1; r0 = -1; v0 = -1; d4 = 0; d0 = 0;
        i4.cmd_valid = 1; i0.cmd_valid = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                i4.cmd_valid = 0; i0.cmd_valid = 0;
            end
            if (i4.en_r && r4 < 0) r4 = c;
            if (i4.rsp_valid && v4 < 0) begin v4 = c; d4 = i4.rsp_data; end
            if (i0.en_r && r0 < 0) r0 = c;
            if (i0.rsp_valid && v0 < 0) begin v0 = c; d0 = i0.rsp_data; end
        end
        vectors++;
        if (r4 !== 7) begin errors++; $error("FAIL t4_e4_en_r_cycle: %0d", r4); end
        vectors++;
        if (v4 !== 8) begin errors++; $error("FAIL t4_e4_rsp_cycle: %0d", v4); end
        vectors++;
        if (d4 !== 8'h5A) begin errors++; $error("FAIL t4_e4_rsp_data: %0h", d4); end
        vectors++;
        if (r0 !== 4) begin errors++; $error("FAIL t4_e0_en_r_cycle: %0d", r0); end
        vectors++;
        if (v0 !== 5) begin errors++; $error("FAIL t4_e0_rsp_cycle: %0d", v0); end
        vectors++;
        if (d0 !== 8'hA5) begin errors++; $error("FAIL t4_e0_rsp_data: %0h", d0); end

        i1.cmd_op = 3'd2; i1.cmd_a = 8'hF0; i1.cmd_b = 8'h3C; i1.cmd_valid = 1; i1.rsp_ready = 1;
        tick();
        i1.cmd_valid = 0;
        tick();
        tick();
        vectors++;
        if (i1.busy !== 1'b1) begin errors++; $error("FAIL t5_exec_busy"); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (i1.busy !== 1'b0) begin errors++; $error("FAIL t5_async_busy"); end
        vectors++;
        if ({i1.en_a, i1.en_b, i1.en_r} !== 3'b000) begin errors++; $error("FAIL t5_async_en"); end
        vectors++;
        if (i1.cmd_ready !== 1'b1) begin errors++; $error("FAIL t5_async_cmd_ready"); end
        vectors++;
        if (i1.alu_op !== 3'd0) begin errors++; $error("FAIL t5_async_alu_op"); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({i1.rsp_valid, i1.busy} !== 2'b00) begin errors++; $error("FAIL t5_no_rsp"); end
            tick();
        end

        i1.cmd_op = 3'd0; i1.cmd_a = 8'h01; i1.cmd_b = 8'h03; i1.cmd_valid = 1; i1.rsp_ready = 1;
        tick();
        vectors++;
        if ({i1.en_a, i1.bus_data} !== {1'b1, 8'h01}) begin errors++; $error("FAIL t6_c1_bus"); end
        i1.cmd_op = 3'd4; i1.cmd_a = 8'h02; i1.cmd_b = 8'h05;
        repeat (4) tick();
        vectors++;
        if ({i1.rsp_valid, i1.rsp_data} !== {1'b1, 8'h04}) begin errors++; $error("FAIL t6_c5_rsp"); end
        vectors++;
        if (i1.cmd_ready !== 1'b0) begin errors++; $error("FAIL t6_c5_cmd_ready"); end
        tick();
        vectors++;
        if ({i1.cmd_ready, i1.busy, i1.rsp_valid} !== 3'b100) begin errors++; $error("FAIL t6_c6_idle"); end
        tick();
        vectors++;
        if ({i1.en_a, i1.bus_data} !== {1'b1, 8'h02}) begin errors++; $error("FAIL t6_c7_bus"); end
        i1.cmd_valid = 0;
        tick();
        vectors++;
        if ({i1.en_b, i1.bus_data} !== {1'b1, 8'h05}) begin errors++; $error("FAIL t6_c8_bus"); end
        repeat (3) tick();
        vectors++;
        if ({i1.rsp_valid, i1.rsp_data} !== {1'b1, 8'h07}) begin errors++; $error("FAIL t6_c11_rsp"); end
        tick();
        vectors++;
        if ({i1.cmd_ready, i1.busy, i1.rsp_valid} !== 3'b100) begin errors++; $error("FAIL t6_c12_idle"); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
